// File: rtl/ifu_fetch_if.sv
// Program-load port for the fetch unit's instruction memory.
// The bench (master) writes words while the core is stopped.
interface ifu_fetch_if #(
    parameter int ADDR_W = 10
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/ifu_fetch.sv
// Single-cycle MIPS fetch: PC register, word-addressed instruction memory,
// next-PC selection with range check, sticky fault and retire counter.
module ifu_fetch #(
    parameter int          IM_DEPTH = 1024,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [1:0]  nPC_sel,
    input  logic        pcReset,
    input  logic        zero,
    ifu_fetch_if.slave  ld,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        pc_fault,
    output logic [31:0] instr_cnt
);
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * IM_DEPTH);

    logic [31:0]       mem [IM_DEPTH];
    logic [31:0]       pc_off;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       npc4;
    logic [31:0]       br_off;
    logic [31:0]       npc;
    logic              npc_legal;

    assign pc_off = pc - RESET_PC;
    assign idx    = ADDR_W'(pc_off >> 2);

    // Once faulted, the fetched word reads as a nop until pcReset/reset.
    assign instr = pc_fault ? 32'h0 : mem[idx];

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];
    assign imm16 = instr[15:0];

    assign npc4     = pc + 32'd4;
    assign pc_plus4 = npc4;
    assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        npc = npc4;
        case (nPC_sel)
            2'b01:   npc = zero ? (npc4 + br_off) : npc4;
            2'b10:   npc = {npc4[31:28], instr[25:0], 2'b00};
            default: npc = npc4;
        endcase
    end

    // Compare at 33 bits so a RESET_PC near the top of the space cannot wrap.
    assign npc_legal = (npc >= RESET_PC) && ({1'b0, npc} < PC_LIMIT) && (npc[1:0] == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            pc_fault  <= 1'b0;
            instr_cnt <= 32'd0;
        end else if (pcReset) begin
            pc       <= RESET_PC;
            pc_fault <= 1'b0;
        end else if (run && !pc_fault) begin
            if (npc_legal) begin
                pc        <= npc;
                instr_cnt <= instr_cnt + 32'd1;
            end else begin
                pc_fault <= 1'b1;
            end
        end
    end

    // Loading is only open while the core is stopped; memory survives reset.
    assign ld.ready = ~run & ~reset;

    always_ff @(posedge clk) begin
        if (ld.valid && ld.ready)
            mem[ld.addr] <= ld.data;
    end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the single-cycle MIPS core.
- Holds the PC and a word-addressed instruction memory, and presents the current instruction's fields (op, funct, rs, rt, rd, imm16) to the main control decoder.
- Takes the decoder's nPC_sel and pcReset outputs, plus the ALU zero flag, and computes the next PC.
- Includes a valid/ready program-load port for filling memory while the core is stopped, a sticky fetch-fault flag, and a retired-instruction counter.

Parameters:
IM_DEPTH, 1024, instruction memory depth in 32-bit words (power of 2)
ADDR_W, 10, log2(IM_DEPTH); width of ld_addr
RESET_PC, 32'h0000_3000, PC value after reset/pcReset; byte address of word 0

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
run  input  1  1 = fetch/advance each cycle; 0 = PC holds, load port enabled
nPC_sel  input  2  next-PC select from decoder: 00 seq, 01 beq, 10 j, 11 reserved
pcReset  input  1  synchronous PC clear to RESET_PC
zero  input  1  ALU equality flag for beq
ld_valid  input  1  program-load request
ld_ready  output  1  load port accepts this cycle
ld_addr  input  ADDR_W  word index to write
ld_data  input  32  instruction word to write
pc  output  32  current PC
pc_plus4  output  32  pc + 4
instr  output  32  current instruction
op  output  6  instr[31:26]
funct  output  6  instr[5:0]
rs  output  5  instr[25:21]
rt  output  5  instr[20:16]
rd  output  5  instr[15:11]
imm16  output  16  instr[15:0]
pc_fault  output  1  sticky: fetch address left memory range
instr_cnt  output  32  retired-instruction count

Behaviour:
- Reset (async, highest priority):
  - pc = RESET_PC, pc_fault = 0, instr_cnt = 0.
  - Instruction memory contents are retained, not cleared.
- Fetch:
  - idx = (pc - RESET_PC) >> 2, truncated to ADDR_W.
  - instr = mem[idx], combinational (zero-latency read); field outputs are slices of instr.
  - While pc_fault = 1, instr = 32'h0 (nop).
- Next PC, with npc4 = pc + 4:
  - 00: npc4.
  - 01: zero=1 gives npc4 + (sign_ext(imm16) << 2); zero=0 gives npc4.
  - 10: {npc4[31:28], instr[25:0], 2'b00}.
  - 11: npc4 (reserved, same as 00).
  - All arithmetic is mod 2^32.
- Range check on candidate next PC:
  - Legal iff npc >= RESET_PC, npc < RESET_PC + 4*IM_DEPTH, and npc[1:0] = 0.
  - Illegal: pc holds, pc_fault <= 1, the cycle does not retire.
- Per-edge priority:
  1. pcReset=1: pc <= RESET_PC, pc_fault <= 0. Applies regardless of run. instr_cnt unchanged.
  2. Otherwise run=0 or pc_fault=1: pc holds.
  3. Otherwise: pc <= npc if legal, and instr_cnt += 1 (wraps at 2^32). If npc is illegal, pc_fault <= 1 and instr_cnt is unchanged.
- Load port:
  - ld_ready = ~run & ~reset.
  - Write mem[ld_addr] <= ld_data on a rising edge with ld_valid & ld_ready.
  - Writing the word at the current idx changes instr from the next cycle.
  - ld_valid while ld_ready=0 is ignored (no write, no queueing).
- Reset asserted mid-run: pc and counters clear immediately (asynchronously); the loaded program survives; fetch restarts at RESET_PC once reset deasserts.
- Simultaneous ld write and run rising: not possible, since the write requires run=0 in that cycle.

Test Plan:
- Load and sequential fetch:
  - Stimulus: reset, run=0; load mem[0..3] = 24010005, 24020005, 00221821, 08000C00 (ld_ready=1); then run=1, nPC_sel=00 for 2 cycles.
  - Required: pc 3000→3004→3008; instr tracks memory; at 3008 op=00, funct=21, rd=3; instr_cnt=2.
- beq:
  - Stimulus: mem[1] = 1000FFFF, pc=3004, nPC_sel=01.
  - Required: zero=1 gives next pc=3004; zero=0 gives next pc=3008.
- j:
  - Stimulus: instr 08000C00 at 300C, nPC_sel=10.
  - Required: next pc=3000; instr_cnt increments.
- Fault:
  - Stimulus: place a j to 00004000 (instr 08001000); execute it.
  - Required: pc_fault=1, pc holds, instr=0, instr_cnt frozen across 5 cycles.
  - Then pcReset=1: pc=3000, pc_fault=0.
- Load gating:
  - Stimulus: run=1, ld_valid=1, ld_addr=0, ld_data=FFFFFFFF.
  - Required: ld_ready=0, mem[0] unchanged.
- Async reset mid-run:
  - Stimulus: assert reset between clock edges at pc=3008.
  - Required: pc=3000 and instr_cnt=0 before the next edge; after release, instr=24010005.
